clock_set_controller: RTL and testbench
=======================================

Name: clock_set_controller

Overview:
- Sequencing controller for the alarm-clock time and alarm counters (seconds, minutes, hours with 12-hour AM/PM).
- Decides each cycle which counter receives a one-cycle increment enable.
- Sources arbitrated: 1 Hz timekeeping tick with carry chain, user increment button (with auto-repeat), and mode button selecting the field being set.
- Sits between debounced push-buttons / tick divider and the counter bank; the counters own all digit arithmetic.

Parameters:
REPEAT_DELAY, 2, number of 1 Hz ticks btn_inc must stay held (after its initial edge) before auto-repeat begins; legal range 1..15.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
tick_1hz  input  1  one-cycle pulse once per second
btn_mode  input  1  debounced mode button, level, active-high
btn_inc  input  1  debounced increment button, level, active-high
sec_max  input  1  seconds counter currently at 59
min_max  input  1  minutes counter currently at 59
mode  output  3  current state encoding (RUN=0, SET_HR=1, SET_MIN=2, SET_AHR=3, SET_AMIN=4)
inc_sec  output  1  increment seconds counter
inc_min  output  1  increment time-minutes counter
inc_hour  output  1  increment time-hours counter (hour counter handles 12→1 and AM/PM toggle)
inc_amin  output  1  increment alarm-minutes counter
inc_ahour  output  1  increment alarm-hours counter
clr_sec  output  1  synchronous clear of seconds counter
blink  output  1  display blank strobe for the field being set

Behaviour:
- Reset (asynchronous, active-high; clock clk):
  - State RUN.
  - All inc_*, clr_sec and blink = 0; repeat counter = 0.
  - Button history registers = 1, so a button held through reset release produces no edge.
- Edge detection: rise_x = btn_x & ~btn_x_q, with btn_x_q registered every cycle.
- All outputs are registered. An event sampled at cycle n appears on outputs for exactly cycle n+1 only. sec_max and min_max are sampled in the same cycle as tick_1hz.
- FSM on rise_mode: RUN→SET_HR→SET_MIN→SET_AHR→SET_AMIN→RUN.
- Entering SET_HR from RUN: clr_sec = 1 for one cycle.
- Simultaneous rise_mode and rise_inc: the mode change wins and the increment is discarded.
- RUN:
  - tick → inc_sec.
  - tick & sec_max → also inc_min.
  - tick & sec_max & min_max → also inc_hour.
  - All of these assert in the same cycle.
  - btn_inc is ignored.
- SET_HR / SET_MIN (time is paused):
  - tick produces no time increments.
  - rise_inc → inc_hour or inc_min respectively.
  - No carry from minutes into hours while setting.
- SET_AHR / SET_AMIN (timekeeping continues exactly as in RUN):
  - rise_inc → inc_ahour or inc_amin.
  - Tick carries and a user increment in the same cycle both assert; they target different counters.
- Auto-repeat (set states only):
  - 4-bit rep_cnt clears on rise_inc, on btn_inc low and on any state change.
  - rep_cnt increments on each tick while btn_inc is held, saturating at REPEAT_DELAY.
  - When a tick arrives with btn_inc held and rep_cnt == REPEAT_DELAY, the selected inc_* pulses, once per tick.
- blink:
  - RUN: 0.
  - Set states: toggles on every tick; forced to 1 on state entry; forced to 1 for the cycle after any user increment.
- At most one pulse per counter per cycle.
- Reset mid-operation (including mid auto-repeat) returns to RUN immediately and drops any pending pulse.
- mode output equals the state register, so it is valid in the same cycle as the state.

Test Plan:
- Reset with btn_mode=1 held, release reset → mode stays 0, no pulse on any output.
- RUN: tick with sec_max=1, min_max=1 → inc_sec, inc_min and inc_hour all 1 in the next cycle only. Tick with sec_max=0 → only inc_sec.
- Press mode from RUN → mode=1, clr_sec pulses once. Then tick → no inc_*. Press inc → one inc_hour pulse.
- Hold btn_inc in SET_MIN with REPEAT_DELAY=2 across 5 ticks → inc_min on the initial edge, then on ticks 3, 4 and 5 (4 pulses total).
- SET_AMIN: rise_inc in the same cycle as tick with sec_max=1 → inc_amin, inc_sec and inc_min all 1 in the same cycle.
- Simultaneous rise_mode and rise_inc in SET_HR → mode=2, no inc_hour. Five mode presses from RUN return to mode=0. Asserting reset during auto-repeat → mode=0, outputs 0.

Source files
------------

// File: rtl/clock_set_controller.sv
// Alarm-clock sequencing controller: arbitrates 1 Hz carries, user increments
// and mode selection into one-cycle increment enables for the counter bank.
module clock_set_controller #(
    parameter int REPEAT_DELAY = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       sec_max,
    input  logic       min_max,
    output logic [2:0] mode,
    output logic       inc_sec,
    output logic       inc_min,
    output logic       inc_hour,
    output logic       inc_amin,
    output logic       inc_ahour,
    output logic       clr_sec,
    output logic       blink
);

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        SET_HR   = 3'd1,
        SET_MIN  = 3'd2,
        SET_AHR  = 3'd3,
        SET_AMIN = 3'd4
    } state_e;

    localparam logic [3:0] REP_MAX = 4'(REPEAT_DELAY);

    state_e     state_q, state_d;
    logic       btn_mode_q, btn_inc_q;
    logic [3:0] rep_cnt_q, rep_cnt_d;
    logic       inc_sec_q, inc_sec_d;
    logic       inc_min_q, inc_min_d;
    logic       inc_hour_q, inc_hour_d;
    logic       inc_amin_q, inc_amin_d;
    logic       inc_ahour_q, inc_ahour_d;
    logic       clr_sec_q, clr_sec_d;
    logic       blink_q, blink_d;

    logic rise_mode, rise_inc;
    logic set_state, keeps_time;
    logic rep_hit, auto_fire, user_inc;
    logic carry_min, carry_hour;

    always_comb begin
        rise_mode  = btn_mode & ~btn_mode_q;
        rise_inc   = btn_inc & ~btn_inc_q;
        set_state  = (state_q != RUN);
        keeps_time = (state_q == RUN) || (state_q == SET_AHR) ||
                     (state_q == SET_AMIN);
        rep_hit    = (rep_cnt_q == REP_MAX);
        auto_fire  = set_state & tick_1hz & btn_inc & rep_hit;
        // A mode press in the same cycle swallows any user increment.
        user_inc   = set_state & ~rise_mode & (rise_inc | auto_fire);
        carry_min  = keeps_time & tick_1hz & sec_max;
        carry_hour = carry_min & min_max;

        state_d = state_q;
        if (rise_mode) begin
            unique case (state_q)
                RUN:      state_d = SET_HR;
                SET_HR:   state_d = SET_MIN;
                SET_MIN:  state_d = SET_AHR;
                SET_AHR:  state_d = SET_AMIN;
                default:  state_d = RUN;
            endcase
        end

        rep_cnt_d = rep_cnt_q;
        if (!set_state || rise_mode || rise_inc || !btn_inc) begin
            rep_cnt_d = 4'd0;
        end else if (tick_1hz && !rep_hit) begin
            rep_cnt_d = rep_cnt_q + 4'd1;
        end

        inc_sec_d   = keeps_time & tick_1hz;
        inc_min_d   = carry_min | (user_inc & (state_q == SET_MIN));
        inc_hour_d  = carry_hour | (user_inc & (state_q == SET_HR));
        inc_amin_d  = user_inc & (state_q == SET_AMIN);
        inc_ahour_d = user_inc & (state_q == SET_AHR);
        clr_sec_d   = rise_mode & (state_q == RUN);

        blink_d = blink_q;
        if (state_d == RUN) begin
            blink_d = 1'b0;
        end else if (rise_mode || user_inc) begin
            blink_d = 1'b1;
        end else if (tick_1hz) begin
            blink_d = ~blink_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            btn_mode_q  <= 1'b1;
            btn_inc_q   <= 1'b1;
            rep_cnt_q   <= 4'd0;
            inc_sec_q   <= 1'b0;
            inc_min_q   <= 1'b0;
            inc_hour_q  <= 1'b0;
            inc_amin_q  <= 1'b0;
            inc_ahour_q <= 1'b0;
            clr_sec_q   <= 1'b0;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            btn_mode_q  <= btn_mode;
            btn_inc_q   <= btn_inc;
            rep_cnt_q   <= rep_cnt_d;
            inc_sec_q   <= inc_sec_d;
            inc_min_q   <= inc_min_d;
            inc_hour_q  <= inc_hour_d;
            inc_amin_q  <= inc_amin_d;
            inc_ahour_q <= inc_ahour_d;
            clr_sec_q   <= clr_sec_d;
            blink_q     <= blink_d;
        end
    end

    assign mode      = state_q;
    assign inc_sec   = inc_sec_q;
    assign inc_min   = inc_min_q;
    assign inc_hour  = inc_hour_q;
    assign inc_amin  = inc_amin_q;
    assign inc_ahour = inc_ahour_q;
    assign clr_sec   = clr_sec_q;
    assign blink     = blink_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller: hand-computed pulses per scenario.
module tb_clock_set_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1hz, btn_mode, btn_inc, sec_max, min_max;
    logic [2:0] mode;
    logic       inc_sec, inc_min, inc_hour, inc_amin, inc_ahour;
    logic       clr_sec, blink;
    logic [5:0] outs;

    int compared = 0;
    int mismatched = 0;

    clock_set_controller #(.REPEAT_DELAY(2)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
        .btn_mode(btn_mode), .btn_inc(btn_inc),
        .sec_max(sec_max), .min_max(min_max), .mode(mode),
        .inc_sec(inc_sec), .inc_min(inc_min), .inc_hour(inc_hour),
        .inc_amin(inc_amin), .inc_ahour(inc_ahour),
        .clr_sec(clr_sec), .blink(blink)
    );

    // {sec, min, hour, amin, ahour, clr_sec}
    assign outs = {inc_sec, inc_min, inc_hour, inc_amin, inc_ahour, clr_sec};

    always #5 clk = ~clk;

    task automatic step(input logic t, input logic bm, input logic bi,
                        input logic sm, input logic mm);
        tick_1hz = t; btn_mode = bm; btn_inc = bi;
        sec_max = sm; min_max = mm;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        compared++;
        if (mode !== 3'd0 || outs !== 6'b0 || blink !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_hold: mode=%0d outs=%b blink=%b want 0/000000/0",
                     mode, outs, blink);
        end
        reset = 1'b0;
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        compared++;
        if (mode !== 3'd0 || outs !== 6'b0) begin
            mismatched++;
            $display("FAIL reset_release: mode=%0d outs=%b want 0/000000",
                     mode, outs);
        end
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_run_tick;
        step(1, 0, 0, 1, 1);
        compared++;
        if (outs !== 6'b111000) begin
            mismatched++;
            $display("FAIL run_full_carry: outs=%b want 111000", outs);
        end
        step(0, 0, 0, 0, 0);
        compared++;
        if (outs !== 6'b0) begin
            mismatched++;
            $display("FAIL run_carry_once: outs=%b want 000000", outs);
        end
        step(1, 0, 0, 0, 1);
        compared++;
        if (outs !== 6'b100000) begin
            mismatched++;
            $display("FAIL run_sec_only: outs=%b want 100000", outs);
        end
        step(0, 0, 1, 0, 0);
        compared++;
        if (outs !== 6'b0 || mode !== 3'd0) begin
            mismatched++;
            $display("FAIL run_ignore_inc: outs=%b mode=%0d want 000000/0",
                     outs, mode);
        end
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_set_hr;
        step(0, 1, 0, 0, 0);
        compared++;
        if (mode !== 3'd1 || outs !== 6'b000001 || blink !== 1'b1) begin
            mismatched++;
            $display("FAIL enter_set_hr: mode=%0d outs=%b blink=%b want 1/000001/1",
                     mode, outs, blink);
        end
        step(0, 0, 0, 0, 0);
        compared++;
        if (outs !== 6'b0) begin
            mismatched++;
            $display("FAIL clr_sec_once: outs=%b want 000000", outs);
        end
        step(1, 0, 0, 1, 1);
        compared++;
        if (outs !== 6'b0 || blink !== 1'b0) begin
            mismatched++;
            $display("FAIL set_hr_paused: outs=%b blink=%b want 000000/0",
                     outs, blink);
        end
        step(0, 0, 1, 0, 0);
        compared++;
        if (outs !== 6'b001000 || blink !== 1'b1) begin
            mismatched++;
            $display("FAIL set_hr_inc: outs=%b blink=%b want 001000/1",
                     outs, blink);
        end
        step(0, 0, 0, 0, 0);
        compared++;
        if (outs !== 6'b0) begin
            mismatched++;
            $display("FAIL set_hr_inc_once: outs=%b want 000000", outs);
        end
    endtask

    task automatic test_simultaneous;
        step(0, 1, 1, 0, 0);
        compared++;
        if (mode !== 3'd2 || outs !== 6'b0) begin
            mismatched++;
            $display("FAIL mode_beats_inc: mode=%0d outs=%b want 2/000000",
                     mode, outs);
        end
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_repeat;
        int pulses = 0;
        step(0, 0, 1, 0, 0);
        compared++;
        if (outs !== 6'b010000) begin
            mismatched++;
            $display("FAIL repeat_edge: outs=%b want 010000", outs);
        end
        if (inc_min === 1'b1) pulses++;
        for (int k = 1; k <= 5; k++) begin
            step(1, 0, 1, 0, 0);
            compared++;
            if (inc_min !== (k >= 3)) begin
                mismatched++;
                $display("FAIL repeat_tick%0d: inc_min=%b want %b",
                         k, inc_min, (k >= 3));
            end
            if (inc_min === 1'b1) pulses++;
            step(0, 0, 1, 0, 0);
            if (inc_min === 1'b1) pulses++;
        end
        compared++;
        if (pulses != 4) begin
            mismatched++;
            $display("FAIL repeat_total: pulses=%0d want 4", pulses);
        end
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_amin;
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        compared++;
        if (mode !== 3'd4) begin
            mismatched++;
            $display("FAIL reach_set_amin: mode=%0d want 4", mode);
        end
        step(1, 0, 1, 1, 0);
        compared++;
        if (outs !== 6'b110100) begin
            mismatched++;
            $display("FAIL amin_with_carry: outs=%b want 110100", outs);
        end
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_mode_wrap;
        logic [2:0] want;
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        compared++;
        if (mode !== 3'd0 || blink !== 1'b0) begin
            mismatched++;
            $display("FAIL amin_to_run: mode=%0d blink=%b want 0/0", mode, blink);
        end
        for (int k = 1; k <= 5; k++) begin
            want = 3'(k % 5);
            step(0, 1, 0, 0, 0);
            compared++;
            if (mode !== want || clr_sec !== (k == 1)) begin
                mismatched++;
                $display("FAIL wrap_press%0d: mode=%0d clr=%b want %0d/%b",
                         k, mode, clr_sec, want, (k == 1));
            end
            step(0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_reset_mid;
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        tick_1hz = 1'b1;
        reset = 1'b1;
        #1;
        compared++;
        if (mode !== 3'd0 || outs !== 6'b0 || blink !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_async: mode=%0d outs=%b blink=%b want 0/000000/0",
                     mode, outs, blink);
        end
        step(1, 0, 1, 0, 0);
        compared++;
        if (mode !== 3'd0 || outs !== 6'b0) begin
            mismatched++;
            $display("FAIL reset_drop: mode=%0d outs=%b want 0/000000", mode, outs);
        end
        reset = 1'b0;
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        compared++;
        if (mode !== 3'd0 || outs !== 6'b0) begin
            mismatched++;
            $display("FAIL reset_after: mode=%0d outs=%b want 0/000000", mode, outs);
        end
        step(0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        tick_1hz = 1'b0; btn_mode = 1'b1; btn_inc = 1'b1;
        sec_max = 1'b0; min_max = 1'b0;
        test_reset();
        test_run_tick();
        test_set_hr();
        test_simultaneous();
        test_repeat();
        test_amin();
        test_mode_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
